// File: rtl/requant_pkg.sv
// Shared encodings and width defaults for the requantizer.
package requant_pkg;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'b00,
    MODE_RELU  = 2'b01,
    MODE_LEAKY = 2'b10
  } mode_e;

  localparam int unsigned DEF_AW = 26;
  localparam int unsigned DEF_MW = 13;
  localparam int unsigned DEF_SW = 6;
  localparam int unsigned DEF_OW = 8;

  // Full-precision product width of an AW x MW signed multiply.
  function automatic int unsigned calc_pw(input int unsigned aw, input int unsigned mw);
    return aw + mw;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One channel of the requantizer datapath: multiply (S1), round/shift (S2),
// activation + saturation (S3). Stage registers load on ld1/ld2/ld3; the
// beat's shift (n) and mode arrive already aligned to S1 and S2 respectively.
module requant_lane
  import requant_pkg::*;
#(
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned MW    = DEF_MW,
  parameter int unsigned SW    = DEF_SW,
  parameter int unsigned OW    = DEF_OW,
  parameter int unsigned LK_SH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld1,
  input  logic                 ld2,
  input  logic                 ld3,
  input  logic signed [AW-1:0] a,
  input  logic signed [MW-1:0] b,
  input  logic        [SW-1:0] n,
  input  logic        [1:0]    mode,
  output logic signed [OW-1:0] y
);

  localparam int unsigned PW = calc_pw(AW, MW);
  localparam logic signed [PW:0] SMAX = (PW+1)'(2**(OW-1) - 1);
  localparam logic signed [PW:0] SMIN = ~SMAX;

  logic signed [PW-1:0] p;
  logic signed [PW:0]   r;
  logic signed [PW:0]   r_nxt;
  logic signed [PW:0]   pe;
  logic signed [PW:0]   half;
  logic signed [PW:0]   v;
  logic signed [OW-1:0] y_nxt;

  // Rounding add is done one bit wider than the product so it cannot overflow.
  always_comb begin
    pe    = (PW+1)'(p);
    half  = '0;
    r_nxt = pe;
    if (n == '0) begin
      r_nxt = pe;
    end else if (int'(n) >= int'(PW)) begin
      r_nxt = '0;
    end else begin
      half  = (PW+1)'(1) << (n - SW'(1));
      r_nxt = (pe + half) >>> n;
    end
  end

  always_comb begin
    v = r;
    case (mode)
      MODE_RELU:  if (r[PW]) v = '0;
      MODE_LEAKY: if (r[PW]) v = r >>> LK_SH;
      default:    v = r;
    endcase
    if (v > SMAX) begin
      y_nxt = SMAX[OW-1:0];
    end else if (v < SMIN) begin
      y_nxt = SMIN[OW-1:0];
    end else begin
      y_nxt = v[OW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
      r <= '0;
      y <= '0;
    end else begin
      if (ld1) p <= PW'(a) * PW'(b);
      if (ld2) r <= r_nxt;
      if (ld3) y <= y_nxt;
    end
  end

endmodule

// File: rtl/requant_pipe.sv
// Multi-channel requantizer: sat(act(round(A*B[ch] >>> n[ch]))) per lane,
// 3-stage valid/ready pipeline. Ports: m_* input beat (data/scale/shift/mode/
// ctrl + valid/ready), s_* output beat (data/ctrl + valid/ready).
module requant_pipe
  import requant_pkg::*;
#(
  parameter int unsigned DN    = 8,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned MW    = DEF_MW,
  parameter int unsigned SW    = DEF_SW,
  parameter int unsigned OW    = DEF_OW,
  parameter int unsigned CW    = 8,
  parameter int unsigned LK_SH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [DN*AW-1:0] m_data,
  input  logic [DN*MW-1:0] m_scale,
  input  logic [DN*SW-1:0] m_shift,
  input  logic [1:0]       m_mode,
  input  logic [CW-1:0]    m_ctrl,
  output logic             s_valid,
  input  logic             s_ready,
  output logic [DN*OW-1:0] s_data,
  output logic [CW-1:0]    s_ctrl
);

  logic v1, v2, v3;
  logic ld1, ld2, ld3;
  logic en1, en2, en3;

  logic [DN*SW-1:0] shift_s1;
  logic [1:0]       mode_s1, mode_s2;
  logic [CW-1:0]    ctrl_s1, ctrl_s2;

  // Ready ripples back from the output: a stage may load when empty or when
  // its successor loads this same cycle.
  assign ld3     = !v3 || s_ready;
  assign ld2     = !v2 || ld3;
  assign ld1     = !v1 || ld2;
  assign m_ready = ld1;
  assign s_valid = v3;

  // Data registers only move when a real beat lands, so s_data holds its
  // last value across bubbles.
  assign en1 = ld1 && m_valid;
  assign en2 = ld2 && v1;
  assign en3 = ld3 && v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      shift_s1 <= '0;
      mode_s1  <= '0;
      mode_s2  <= '0;
      ctrl_s1  <= '0;
      ctrl_s2  <= '0;
      s_ctrl   <= '0;
    end else begin
      if (ld1) v1 <= m_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
      if (en1) begin
        shift_s1 <= m_shift;
        mode_s1  <= m_mode;
        ctrl_s1  <= m_ctrl;
      end
      if (en2) begin
        mode_s2 <= mode_s1;
        ctrl_s2 <= ctrl_s1;
      end
      if (en3) s_ctrl <= ctrl_s2;
    end
  end

  for (genvar i = 0; i < DN; i++) begin : g_lane
    requant_lane #(
      .AW   (AW),
      .MW   (MW),
      .SW   (SW),
      .OW   (OW),
      .LK_SH(LK_SH)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .ld1  (en1),
      .ld2  (en2),
      .ld3  (en3),
      .a    (m_data[i*AW +: AW]),
      .b    (m_scale[i*MW +: MW]),
      .n    (shift_s1[i*SW +: SW]),
      .mode (mode_s2),
      .y    (s_data[i*OW +: OW])
    );
  end

endmodule

// File: tb/tb_requant_pipe.sv
module tb_requant_pipe;

  localparam int DN = 8, AW = 26, MW = 13, SW = 6, OW = 8, CW = 8, LK_SH = 3;
  localparam longint SMAXL = (longint'(1) << (OW-1)) - 1;
  localparam longint SMINL = -SMAXL - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             m_valid;
  logic             m_ready;
  logic [DN*AW-1:0] m_data;
  logic [DN*MW-1:0] m_scale;
  logic [DN*SW-1:0] m_shift;
  logic [1:0]       m_mode;
  logic [CW-1:0]    m_ctrl;
  logic             s_valid;
  logic             s_ready;
  logic [DN*OW-1:0] s_data;
  logic [CW-1:0]    s_ctrl;

  always #5 clk = ~clk;

  requant_pipe #(
    .DN(DN), .AW(AW), .MW(MW), .SW(SW), .OW(OW), .CW(CW), .LK_SH(LK_SH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_scale(m_scale),
    .m_shift(m_shift), .m_mode(m_mode), .m_ctrl(m_ctrl),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ctrl(s_ctrl)
  );

  typedef struct packed {
    logic [DN*OW-1:0] d;
    logic [CW-1:0]    c;
  } exp_t;

  exp_t   q[$];
  int     checks = 0, errors = 0, tx_count = 0, rx_count = 0, cyc = 0;
  bit     stall_seen;
  longint la[DN], lb[DN], le[DN];
  int     ln[DN];

  always @(posedge clk) cyc++;

  function automatic longint model(longint a, longint b, int n, logic [1:0] mode);
    longint p, r;
    p = a * b;
    if (n == 0) r = p;
    else if (n >= AW + MW) r = 0;
    else r = (p + (longint'(1) << (n - 1))) >>> n;
    if (mode == 2'b01 && r < 0) r = 0;
    else if (mode == 2'b10 && r < 0) r = r >>> LK_SH;
    if (r > SMAXL) r = SMAXL;
    if (r < SMINL) r = SMINL;
    return r;
  endfunction

  task automatic lane(int i, longint a, longint b, int n, longint e);
    la[i] = a; lb[i] = b; ln[i] = n; le[i] = e;
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < DN; i++) lane(i, 0, 0, 0, 0);
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < DN; i++) begin
      la[i] = longint'($urandom_range(0, (1 << AW) - 1)) - (longint'(1) << (AW-1));
      lb[i] = longint'($urandom_range(0, (1 << MW) - 1)) - (longint'(1) << (MW-1));
      ln[i] = int'($urandom_range(20, 45));
    end
  endtask

  // Drives one beat and returns #1 after the edge that captured it.
  task automatic send_beat(input logic [1:0] mode, input logic [CW-1:0] ctrl, input bit use_model);
    exp_t e;
    bit   acc;
    int   w;
    for (int i = 0; i < DN; i++) begin
      m_data[i*AW +: AW]  = AW'(la[i]);
      m_scale[i*MW +: MW] = MW'(lb[i]);
      m_shift[i*SW +: SW] = SW'(ln[i]);
      e.d[i*OW +: OW]     = OW'(use_model ? model(la[i], lb[i], ln[i], mode) : le[i]);
    end
    e.c = ctrl;
    m_mode = mode; m_ctrl = ctrl; m_valid = 1'b1;
    acc = 1'b0; w = 0;
    while (!acc && w < 50) begin
      @(negedge clk);
      acc = m_ready;
      if (!acc) stall_seen = 1'b1;
      @(posedge clk); #1;
      w++;
    end
    checks++;
    assert (acc === 1'b1) else begin
      errors++; $error("FAIL send_timeout: m_ready got %b exp 1", acc);
    end
    if (acc) begin
      q.push_back(e);
      tx_count++;
    end
  endtask

  task automatic send_lat(input logic [1:0] mode, input logic [CW-1:0] ctrl);
    int cnt;
    send_beat(mode, ctrl, 1'b0);
    m_valid = 1'b0;
    cnt = 1;
    while (s_valid !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    assert (cnt === 3) else begin
      errors++; $error("FAIL latency: got %0d exp 3", cnt);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    checks++;
    assert (q.size() === 0) else begin
      errors++; $error("FAIL drain: pending got %0d exp 0", q.size());
    end
  endtask

  // Scoreboard: every cycle s_valid is up, s_data must equal the oldest
  // outstanding beat (this also covers stability while stalled).
  always @(negedge clk) begin
    if (rst_n === 1'b1 && s_valid === 1'b1) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++; $error("FAIL unexpected_beat: s_data %h ctrl %h, exp none", s_data, s_ctrl);
      end
      if (q.size() > 0) begin
        checks++;
        assert (s_data === q[0].d) else begin
          errors++; $error("FAIL s_data: got %h exp %h", s_data, q[0].d);
        end
        checks++;
        assert (s_ctrl === q[0].c) else begin
          errors++; $error("FAIL s_ctrl: got %h exp %h", s_ctrl, q[0].c);
        end
        if (s_ready === 1'b1) begin
          q.delete(0);
          rx_count++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    rst_n = 1'b0; m_valid = 1'b0; s_ready = 1'b1;
    m_data = '0; m_scale = '0; m_shift = '0; m_mode = '0; m_ctrl = '0;
    clear_lanes();
    repeat (3) @(posedge clk);
    #1;
    checks++; assert (s_valid === 1'b0) else begin errors++; $error("FAIL rst_s_valid: got %b exp 0", s_valid); end
    checks++; assert (s_data === '0) else begin errors++; $error("FAIL rst_s_data: got %h exp 0", s_data); end
    checks++; assert (s_ctrl === '0) else begin errors++; $error("FAIL rst_s_ctrl: got %h exp 0", s_ctrl); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; assert (m_ready === 1'b1) else begin errors++; $error("FAIL rst_m_ready: got %b exp 1", m_ready); end
    @(posedge clk); #1;

    // Basic values, rounding ties, n=0 and saturation in one beat.
    lane(0,   1000,   3, 5,   94);
    lane(1,  -1000,   3, 5,  -94);
    lane(2,     16,   3, 5,    2);
    lane(3,    -16,   3, 5,   -1);
    lane(4,     16,   1, 5,    1);
    lane(5,    -16,   1, 5,    0);
    lane(6,     -7,   1, 0,   -7);
    lane(7, 100000, 100, 4,  127);
    send_lat(2'b00, 8'hA5);

    lane(0,   -100000,   100,  4, -128);
    lane(1,     12345, -4000, 63,    0);
    lane(2,     -1000,     3,  5,  -94);
    lane(3,      1600,     1,  5,   50);
    lane(4,  33554431,  4095,  0,  127);
    lane(5, -33554432, -4096,  0,  127);
    lane(6, -33554432,  4095,  0, -128);
    lane(7,         5,     7, 39,    0);
    send_beat(2'b00, 8'h5A, 1'b0);

    // Activation modes back to back; each beat carries its own mode.
    clear_lanes();
    lane(0, -1000, 3, 5, 0);
    lane(1,  1600, 1, 5, 50);
    send_beat(2'b01, 8'h01, 1'b0);
    lane(0,   -1000,   3, 5,  -12);
    lane(2, -100000, 100, 4, -128);
    lane(3,     -80,   1, 0,  -10);
    send_beat(2'b10, 8'h02, 1'b0);
    clear_lanes();
    lane(0, -1000, 3, 5, -94);
    lane(1,  1600, 1, 5,  50);
    send_beat(2'b11, 8'h03, 1'b0);
    m_valid = 1'b0;
    drain();

    // Full throughput with s_ready high: 8 beats in 8 cycles.
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      rand_lanes();
      send_beat(2'($urandom_range(0, 3)), CW'(8'h10 + k), 1'b1);
    end
    m_valid = 1'b0;
    checks++;
    assert (cyc - t0 === 8) else begin errors++; $error("FAIL throughput: cycles got %0d exp 8", cyc - t0); end
    drain();

    // Backpressure: s_ready low for cycles 4-7 while streaming.
    stall_seen = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          rand_lanes();
          send_beat(2'($urandom_range(0, 3)), CW'(8'h20 + k), 1'b1);
        end
        m_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 s_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 s_ready = 1'b1;
      end
    join
    checks++;
    assert (stall_seen === 1'b1) else begin errors++; $error("FAIL bp_m_ready_drop: got %b exp 1", stall_seen); end
    drain();
    checks++;
    assert (rx_count === tx_count) else begin errors++; $error("FAIL beat_count: got %0d exp %0d", rx_count, tx_count); end

    // Reset with beats in flight.
    clear_lanes();
    s_ready = 1'b0;
    lane(0, 1000, 3, 5, 94);
    send_beat(2'b00, 8'hC1, 1'b0);
    m_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lane(0, 2000, 3, 5, 0);
    send_beat(2'b00, 8'hC2, 1'b0);
    send_beat(2'b00, 8'hC3, 1'b0);
    m_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; assert (s_valid === 1'b0) else begin errors++; $error("FAIL mid_rst_s_valid: got %b exp 0", s_valid); end
    checks++; assert (s_data === '0) else begin errors++; $error("FAIL mid_rst_s_data: got %h exp 0", s_data); end
    q.delete();
    tx_count = 0; rx_count = 0;
    s_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    clear_lanes();
    lane(0, -1000, 3, 5, -12);
    lane(5, 1600, 1, 5, 50);
    send_lat(2'b10, 8'h77);
    drain();
    checks++;
    assert (rx_count === tx_count) else begin errors++; $error("FAIL post_rst_count: got %0d exp %0d", rx_count, tx_count); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
